// File: rtl/ssd_scan_ctrl_if.sv
// Handshake and display bus for the 4-digit seven-segment scan controller.
//   master : value producer / display consumer (drives load, bcd, neg, lzb)
//   slave  : ssd_scan_ctrl (drives ready, ack, err, code, an)
interface ssd_scan_ctrl_if;
  logic        ssd_scan_ctrl_port_load;   // capture request, honoured while ready=1
  logic [11:0] ssd_scan_ctrl_port_bcd;    // [11:8] hundreds, [7:4] tens, [3:0] ones
  logic        ssd_scan_ctrl_port_neg;    // 1 = negative result
  logic        ssd_scan_ctrl_port_lzb;    // 1 = leading-zero blanking
  logic        ssd_scan_ctrl_port_ready;  // 1 = load will be accepted
  logic        ssd_scan_ctrl_port_ack;    // one-cycle pulse when captured value is visible
  logic        ssd_scan_ctrl_port_err;    // sticky: last committed value had a nibble > 9
  logic [3:0]  ssd_scan_ctrl_port_code;   // digit code (0-9, A blank, E plus, F minus)
  logic [3:0]  ssd_scan_ctrl_port_an;     // anodes, active low; an[0] = ones, an[3] = sign

  modport master (
    output ssd_scan_ctrl_port_load, ssd_scan_ctrl_port_bcd,
           ssd_scan_ctrl_port_neg, ssd_scan_ctrl_port_lzb,
    input  ssd_scan_ctrl_port_ready, ssd_scan_ctrl_port_ack,
           ssd_scan_ctrl_port_err, ssd_scan_ctrl_port_code, ssd_scan_ctrl_port_an
  );

  modport slave (
    input  ssd_scan_ctrl_port_load, ssd_scan_ctrl_port_bcd,
           ssd_scan_ctrl_port_neg, ssd_scan_ctrl_port_lzb,
    output ssd_scan_ctrl_port_ready, ssd_scan_ctrl_port_ack,
           ssd_scan_ctrl_port_err, ssd_scan_ctrl_port_code, ssd_scan_ctrl_port_an
  );
endinterface

// File: rtl/ssd_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit common-anode seven-segment
// display. Holds a latched signed 3-digit BCD value, steps one digit slot every
// REFRESH_DIV cycles, blanks all anodes for GUARD cycles at each slot start,
// and only commits new values at slot boundaries so a number never tears.
// Ports:
//   ssd_scan_ctrl_port_clk   : system clock, rising edge
//   ssd_scan_ctrl_port_rst_n : asynchronous active-low reset
//   bus (slave)              : load/bcd/neg/lzb in; ready/ack/err/code/an out
module ssd_scan_ctrl #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned GUARD       = 2
) (
  input  logic          ssd_scan_ctrl_port_clk,
  input  logic          ssd_scan_ctrl_port_rst_n,
  ssd_scan_ctrl_if.slave bus
);

  localparam int unsigned PW     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] LAST    = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] GUARD_W = PW'(GUARD);

  localparam logic [3:0] C_BLANK = 4'hA;
  localparam logic [3:0] C_PLUS  = 4'hE;
  localparam logic [3:0] C_MINUS = 4'hF;

  typedef enum logic {ST_RUN, ST_PEND} state_t;

  state_t      state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]  idx_q, idx_d;
  logic [11:0] stg_bcd_q, stg_bcd_d;
  logic        stg_neg_q, stg_neg_d;
  logic        stg_lzb_q, stg_lzb_d;
  logic        disp_vld_q, disp_vld_d;
  logic [11:0] disp_bcd_q, disp_bcd_d;
  logic        disp_neg_q, disp_neg_d;
  logic        disp_lzb_q, disp_lzb_d;
  logic        err_q, err_d;
  logic        ack_q, ack_d;
  logic        ready;
  logic        tick;

  logic [3:0] hun, ten, one;
  logic [3:0] code;
  logic [3:0] an;

  function automatic logic nib_bad(input logic [3:0] n);
    return n > 4'd9;
  endfunction

  assign tick = (presc_q == LAST);

  always_ff @(posedge ssd_scan_ctrl_port_clk or negedge ssd_scan_ctrl_port_rst_n) begin
    if (!ssd_scan_ctrl_port_rst_n) begin
      state_q    <= ST_RUN;
      presc_q    <= '0;
      idx_q      <= '0;
      stg_bcd_q  <= '0;
      stg_neg_q  <= 1'b0;
      stg_lzb_q  <= 1'b0;
      disp_vld_q <= 1'b0;
      disp_bcd_q <= '0;
      disp_neg_q <= 1'b0;
      disp_lzb_q <= 1'b0;
      err_q      <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      stg_bcd_q  <= stg_bcd_d;
      stg_neg_q  <= stg_neg_d;
      stg_lzb_q  <= stg_lzb_d;
      disp_vld_q <= disp_vld_d;
      disp_bcd_q <= disp_bcd_d;
      disp_neg_q <= disp_neg_d;
      disp_lzb_q <= disp_lzb_d;
      err_q      <= err_d;
      ack_q      <= ack_d;
    end
  end

  // Prescaler and slot index.
  always_comb begin
    presc_d = presc_q + 1'b1;
    idx_d   = idx_q;
    if (tick) begin
      presc_d = '0;
      idx_d   = idx_q + 2'd1;
    end
  end

  // Load/commit FSM. A load that lands on a tick edge only captures; the
  // commit happens on the next tick, which keeps every commit aligned to a
  // slot boundary.
  always_comb begin
    state_d    = state_q;
    stg_bcd_d  = stg_bcd_q;
    stg_neg_d  = stg_neg_q;
    stg_lzb_d  = stg_lzb_q;
    disp_vld_d = disp_vld_q;
    disp_bcd_d = disp_bcd_q;
    disp_neg_d = disp_neg_q;
    disp_lzb_d = disp_lzb_q;
    err_d      = err_q;
    ack_d      = 1'b0;
    ready      = 1'b0;
    case (state_q)
      ST_RUN: begin
        ready = 1'b1;
        if (bus.ssd_scan_ctrl_port_load) begin
          stg_bcd_d = bus.ssd_scan_ctrl_port_bcd;
          stg_neg_d = bus.ssd_scan_ctrl_port_neg;
          stg_lzb_d = bus.ssd_scan_ctrl_port_lzb;
          state_d   = ST_PEND;
        end
      end
      ST_PEND: begin
        if (tick) begin
          disp_vld_d = 1'b1;
          disp_bcd_d = stg_bcd_q;
          disp_neg_d = stg_neg_q;
          disp_lzb_d = stg_lzb_q;
          err_d      = nib_bad(stg_bcd_q[11:8]) | nib_bad(stg_bcd_q[7:4]) |
                       nib_bad(stg_bcd_q[3:0]);
          ack_d      = 1'b1;
          state_d    = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Digit code for the current slot.
  assign hun = disp_bcd_q[11:8];
  assign ten = disp_bcd_q[7:4];
  assign one = disp_bcd_q[3:0];

  always_comb begin
    code = C_BLANK;
    if (disp_vld_q) begin
      case (idx_q)
        2'd0: code = nib_bad(one) ? C_BLANK : one;
        2'd1: begin
          if (nib_bad(ten) || (disp_lzb_q && ten == 4'd0 && hun == 4'd0)) code = C_BLANK;
          else                                                           code = ten;
        end
        2'd2: code = (nib_bad(hun) || (disp_lzb_q && hun == 4'd0)) ? C_BLANK : hun;
        default: begin
          if (disp_bcd_q == 12'h000) code = C_BLANK;
          else                       code = disp_neg_q ? C_MINUS : C_PLUS;
        end
      endcase
    end
  end

  always_comb begin
    if (presc_q < GUARD_W) an = '1;
    else                   an = ~(4'b0001 << idx_q);
  end

  assign bus.ssd_scan_ctrl_port_ready = ready;
  assign bus.ssd_scan_ctrl_port_ack   = ack_q;
  assign bus.ssd_scan_ctrl_port_err   = err_q;
  assign bus.ssd_scan_ctrl_port_code  = code;
  assign bus.ssd_scan_ctrl_port_an    = an;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
module tb_ssd_scan_ctrl;

  localparam int unsigned DIV = 8;
  localparam int unsigned GRD = 2;

  logic clk;
  logic rst_n;
  int   tests;
  int   failed;

  ssd_scan_ctrl_if bus ();

  ssd_scan_ctrl #(.REFRESH_DIV(DIV), .GUARD(GRD)) dut (
    .ssd_scan_ctrl_port_clk   (clk),
    .ssd_scan_ctrl_port_rst_n (rst_n),
    .bus                      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model of the prescaler phase and slot index.
  int ph;
  int idxm;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph   <= 0;
      idxm <= 0;
    end else begin
      ph <= (ph + 1) % DIV;
      if (ph == DIV - 1) idxm <= (idxm + 1) % 4;
    end
  end

  typedef struct {
    logic [11:0]     bcd;
    logic            neg;
    logic            lzb;
    int              p;      // prescaler phase in which load is driven
    logic [3:0][3:0] codes;  // expected code per slot [3]=sign .. [0]=ones
    logic            err;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_frame(input logic [3:0][3:0] exp_codes, input logic exp_err);
    logic [3:0] exp_an;
    for (int c = 0; c < 4 * DIV; c++) begin
      @(negedge clk);
      exp_an = (ph < GRD) ? 4'hF : ~(4'b0001 << idxm);
      chk("an", 32'(bus.ssd_scan_ctrl_port_an), 32'(exp_an));
      chk("code", 32'(bus.ssd_scan_ctrl_port_code), 32'(exp_codes[idxm]));
      chk("ack_idle", 32'(bus.ssd_scan_ctrl_port_ack), 32'd0);
    end
    chk("err", 32'(bus.ssd_scan_ctrl_port_err), 32'(exp_err));
  endtask

  task automatic wait_phase(input int p);
    int k;
    k = 0;
    while (!(ph == p && bus.ssd_scan_ctrl_port_ready === 1'b1) && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (k >= 40) chk("phase_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int n;
    int rlow;
    int exp_n;
    tests  = 0;
    failed = 0;
    rst_n  = 1'b0;
    bus.ssd_scan_ctrl_port_load = 1'b0;
    bus.ssd_scan_ctrl_port_bcd  = '0;
    bus.ssd_scan_ctrl_port_neg  = 1'b0;
    bus.ssd_scan_ctrl_port_lzb  = 1'b0;

    vecs[0] = '{12'h123, 1'b1, 1'b0, 4, {4'hF, 4'h1, 4'h2, 4'h3}, 1'b0};
    vecs[1] = '{12'h005, 1'b0, 1'b1, 0, {4'hE, 4'hA, 4'hA, 4'h5}, 1'b0};
    vecs[2] = '{12'h005, 1'b0, 1'b0, 6, {4'hE, 4'h0, 4'h0, 4'h5}, 1'b0};
    vecs[3] = '{12'h000, 1'b0, 1'b1, 2, {4'hA, 4'hA, 4'hA, 4'h0}, 1'b0};
    vecs[4] = '{12'h1C4, 1'b0, 1'b0, 3, {4'hE, 4'h1, 4'hA, 4'h4}, 1'b1};
    vecs[5] = '{12'h042, 1'b0, 1'b0, 5, {4'hE, 4'h0, 4'h4, 4'h2}, 1'b0};
    vecs[6] = '{12'h000, 1'b1, 1'b0, 7, {4'hA, 4'h0, 4'h0, 4'h0}, 1'b0};
    vecs[7] = '{12'h090, 1'b1, 1'b1, 1, {4'hF, 4'hA, 4'h9, 4'h0}, 1'b0};

    // Reset, run part of a slot, then reset again mid-count.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_code", 32'(bus.ssd_scan_ctrl_port_code), 32'hA);
    chk("rst_an", 32'(bus.ssd_scan_ctrl_port_an), 32'hF);
    chk("rst_ready", 32'(bus.ssd_scan_ctrl_port_ready), 32'd1);
    chk("rst_err", 32'(bus.ssd_scan_ctrl_port_err), 32'd0);
    chk("rst_ack", 32'(bus.ssd_scan_ctrl_port_ack), 32'd0);
    check_frame({4'hA, 4'hA, 4'hA, 4'hA}, 1'b0);

    // Table-driven loads at various prescaler phases.
    foreach (vecs[i]) begin
      wait_phase(vecs[i].p);
      bus.ssd_scan_ctrl_port_load = 1'b1;
      bus.ssd_scan_ctrl_port_bcd  = vecs[i].bcd;
      bus.ssd_scan_ctrl_port_neg  = vecs[i].neg;
      bus.ssd_scan_ctrl_port_lzb  = vecs[i].lzb;
      n    = 0;
      rlow = 0;
      do begin
        @(negedge clk);
        bus.ssd_scan_ctrl_port_load = 1'b0;
        bus.ssd_scan_ctrl_port_bcd  = '0;
        n++;
        if (bus.ssd_scan_ctrl_port_ready === 1'b0) rlow++;
      end while (bus.ssd_scan_ctrl_port_ack !== 1'b1 && n < 40);
      exp_n = (vecs[i].p == DIV - 1) ? DIV + 1 : DIV - vecs[i].p;
      chk("ack_latency", 32'(n), 32'(exp_n));
      chk("ready_low_cycles", 32'(rlow), 32'(exp_n - 1));
      chk("ready_at_ack", 32'(bus.ssd_scan_ctrl_port_ready), 32'd1);
      check_frame(vecs[i].codes, vecs[i].err);
    end

    // Load coincident with tick; a second load during PEND is ignored.
    wait_phase(DIV - 1);
    bus.ssd_scan_ctrl_port_load = 1'b1;
    bus.ssd_scan_ctrl_port_bcd  = 12'h321;
    bus.ssd_scan_ctrl_port_neg  = 1'b0;
    bus.ssd_scan_ctrl_port_lzb  = 1'b0;
    @(negedge clk);
    bus.ssd_scan_ctrl_port_load = 1'b0;
    n = 1;
    repeat (2) begin
      @(negedge clk);
      n++;
    end
    chk("pend_ready", 32'(bus.ssd_scan_ctrl_port_ready), 32'd0);
    bus.ssd_scan_ctrl_port_load = 1'b1;
    bus.ssd_scan_ctrl_port_bcd  = 12'h999;
    bus.ssd_scan_ctrl_port_neg  = 1'b1;
    do begin
      @(negedge clk);
      bus.ssd_scan_ctrl_port_load = 1'b0;
      n++;
    end while (bus.ssd_scan_ctrl_port_ack !== 1'b1 && n < 40);
    chk("tick_load_latency", 32'(n), 32'(DIV + 1));
    check_frame({4'hE, 4'h3, 4'h2, 4'h1}, 1'b0);

    // Reset while PEND drops the staged value.
    wait_phase(0);
    bus.ssd_scan_ctrl_port_load = 1'b1;
    bus.ssd_scan_ctrl_port_bcd  = 12'h777;
    bus.ssd_scan_ctrl_port_neg  = 1'b1;
    @(negedge clk);
    bus.ssd_scan_ctrl_port_load = 1'b0;
    @(negedge clk);
    chk("pend_before_rst", 32'(bus.ssd_scan_ctrl_port_ready), 32'd0);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_frame({4'hA, 4'hA, 4'hA, 4'hA}, 1'b0);
    check_frame({4'hA, 4'hA, 4'hA, 4'hA}, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/ssd_scan_ctrl.md
Name: ssd_scan_ctrl

Overview:
- Time-multiplexed scan controller for a 4-digit common-anode seven-segment display in the calculator.
- Holds a latched signed 3-digit BCD result and steps through the digits.
- Presents one 4-bit digit code per slot to the combinational seven-segment encoder and drives the matching anode.
- Takes new values through a load/ready/ack handshake; values commit only at slot boundaries, so the displayed number never tears mid-scan.

Parameters:
- REFRESH_DIV, 100000: clock cycles per digit slot (≥ GUARD+2).
- GUARD, 2: cycles at slot start with all anodes off (anti-ghosting); 0 disables.

Ports:
- ssd_scan_ctrl_port_clk  in  1  system clock, rising edge.
- ssd_scan_ctrl_port_rst_n  in  1  asynchronous active-low reset.
- ssd_scan_ctrl_port_load  in  1  request to capture bcd/neg/lzb; honoured only while ready=1.
- ssd_scan_ctrl_port_bcd  in  12  magnitude: [11:8] hundreds, [7:4] tens, [3:0] ones.
- ssd_scan_ctrl_port_neg  in  1  1 = negative result.
- ssd_scan_ctrl_port_lzb  in  1  1 = leading-zero blanking enabled.
- ssd_scan_ctrl_port_ready  out  1  1 = load will be accepted.
- ssd_scan_ctrl_port_ack  out  1  one-cycle pulse when captured value becomes visible.
- ssd_scan_ctrl_port_err  out  1  sticky; last committed value had a nibble >9.
- ssd_scan_ctrl_port_code  out  4  digit code to encoder (0-9 digit, A blank, E plus, F minus).
- ssd_scan_ctrl_port_an  out  4  anodes, active low; an[0] = ones, an[3] = sign position.

Behaviour:
- Reset (async assert, synchronous-to-clk release):
  - prescaler=0, idx=0, state=RUN, ready=1, ack=0, err=0.
  - Display regs = "no value": code=A for every slot, an=4'b1111.
  - Reset mid-PEND discards staging; nothing commits.
- Prescaler:
  - Counts 0..REFRESH_DIV-1; tick = (prescaler==REFRESH_DIV-1).
  - On tick: prescaler→0, idx→idx+1 mod 4 (0→1→2→3→0).
- Anodes:
  - an=4'b1111 while prescaler<GUARD.
  - Otherwise an = ~(1<<idx).
- code: combinational from idx and display regs.
  - Slot 0: ones. Slot 1: tens. Slot 2: hundreds. Slot 3: E if neg=0, F if neg=1; A if value is zero (sign suppressed for 0).
  - Before the first commit, all slots show A.
- Leading-zero blanking (lzb=1):
  - Hundreds shows A if 0.
  - Tens shows A if tens=0 and hundreds=0.
  - Ones is never blanked.
  - lzb=0 shows all digits.
- Invalid nibble (>9) in a committed value: that slot shows A; err=1 until the next commit with all nibbles valid.
- FSM, two states:
  - RUN: ready=1. load=1 → staging←{bcd,neg,lzb}, ready→0, state→PEND.
  - PEND: ready=0; load ignored. On the next tick edge: display←staging, err updated, state→RUN, ready→1, ack=1 during the following single cycle.
- Simultaneous events:
  - load and tick in the same RUN cycle: capture only; commit waits for the following tick (latency REFRESH_DIV cycles).
  - Worst-case load→visible latency is REFRESH_DIV cycles. Best case is 1 cycle (load one cycle before tick).
  - load asserted in the ack cycle is accepted (ready=1 then).
- Commit coincides with the idx advance, so the new value first appears at the start of the new slot (after its guard).

Test Plan (REFRESH_DIV=8, GUARD=2):
- Reset: hold rst_n=0 mid-count, release → code=A, an=1111, ready=1, err=0; after 2 cycles an=1110, code=A.
- Load bcd=12'h123, neg=1, lzb=0 three cycles before a tick → ready=0 for 3 cycles, ack high 1 cycle after tick edge. Following slots show codes 1/2 (tens)/1 (hundreds)/F on an=1101,1011,0111,1110 with matching codes 2,1,F,3.
- Load bcd=12'h005, neg=0, lzb=1 → slots show 5, A, A, E. Same with lzb=0 → 5, 0, 0, E. bcd=12'h000, lzb=1 → 0, A, A, A.
- Load pulse coincident with tick in RUN → commit exactly 8 cycles later. Second load during PEND (bcd=12'h999) → ignored; the display shows the first value.
- Load bcd=12'h1C4 → tens slot shows A and err=1. Next load 12'h042 → err=0.
- Assert rst_n=0 while in PEND → staging is dropped; after release the display is all A and ack never pulses.
